// File: rtl/rsa_job_sequencer_if.sv
// rsa_job_sequencer_if: request, control-core and response signals of the RSA job sequencer
interface rsa_job_sequencer_if #(parameter int WIDTH = 128);
  logic                 req_valid;
  logic                 req_ready;
  logic [WIDTH-1:0]     req_p;
  logic [WIDTH-1:0]     req_q;
  logic                 req_mode;
  logic [2*WIDTH-1:0]   req_msg;
  logic [WIDTH-1:0]     core_p;
  logic [WIDTH-1:0]     core_q;
  logic                 core_encrypt_decrypt;
  logic [2*WIDTH-1:0]   core_msg_in;
  logic                 core_reset_inverter;
  logic                 core_reset_mod_exp;
  logic                 core_inverter_finish;
  logic                 core_mod_exp_finish;
  logic [2*WIDTH-1:0]   core_msg_out;
  logic                 rsp_valid;
  logic                 rsp_ready;
  logic [2*WIDTH-1:0]   rsp_msg;
  logic                 rsp_timeout;
  modport slave (
    input  req_valid, req_p, req_q, req_mode, req_msg,
    input  core_inverter_finish, core_mod_exp_finish, core_msg_out, rsp_ready,
    output req_ready, core_p, core_q, core_encrypt_decrypt, core_msg_in,
    output core_reset_inverter, core_reset_mod_exp, rsp_valid, rsp_msg, rsp_timeout
  );
  modport master (
    output req_valid, req_p, req_q, req_mode, req_msg,
    output core_inverter_finish, core_mod_exp_finish, core_msg_out, rsp_ready,
    input  req_ready, core_p, core_q, core_encrypt_decrypt, core_msg_in,
    input  core_reset_inverter, core_reset_mod_exp, rsp_valid, rsp_msg, rsp_timeout
  );
endinterface

// File: rtl/rsa_job_sequencer.sv
// rsa_job_sequencer: runs one RSA job through inverter then mod-exp phases of a control core, with per-phase timeout
module rsa_job_sequencer #(
  parameter int WIDTH   = 128,
  parameter int TIMEOUT = 1048576
) (
  input  logic                 clk,
  input  logic                 reset,
  rsa_job_sequencer_if.slave   bus,
  output logic                 busy,
  output logic [15:0]          job_count
);
  localparam int CW = $clog2(TIMEOUT + 1);
  typedef enum logic [2:0] {IDLE, INV_RST, INV_WAIT, EXP_RST, EXP_WAIT, RESP} state_t;
  state_t               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [WIDTH-1:0]     p_q, p_d, q_q, q_d;
  logic                 mode_q, mode_d;
  logic [2*WIDTH-1:0]   msg_q, msg_d, rsp_msg_q, rsp_msg_d;
  logic                 to_q, to_d;
  logic [15:0]          jobs_q, jobs_d;
  logic                 accept, expired, exp_done, to_exit;
  // all state and datapath flops, cleared together so a mid-job reset leaves no trace
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      p_q       <= '0;
      q_q       <= '0;
      mode_q    <= 1'b0;
      msg_q     <= '0;
      rsp_msg_q <= '0;
      to_q      <= 1'b0;
      jobs_q    <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      p_q       <= p_d;
      q_q       <= q_d;
      mode_q    <= mode_d;
      msg_q     <= msg_d;
      rsp_msg_q <= rsp_msg_d;
      to_q      <= to_d;
      jobs_q    <= jobs_d;
    end
  end
  // next state: finish flags only matter in their own WAIT state, and finish beats expiry
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     state_d = bus.req_valid ? INV_RST : IDLE;
      INV_RST:  state_d = INV_WAIT;
      INV_WAIT: state_d = bus.core_inverter_finish ? EXP_RST : expired ? RESP : INV_WAIT;
      EXP_RST:  state_d = EXP_WAIT;
      EXP_WAIT: state_d = (bus.core_mod_exp_finish || expired) ? RESP : EXP_WAIT;
      RESP:     state_d = bus.rsp_ready ? IDLE : RESP;
      default:  state_d = IDLE;
    endcase
  end
  // job capture, wait counter (zero outside WAIT so each phase starts fresh), result capture
  always_comb begin
    accept    = state_q == IDLE && bus.req_valid;
    expired   = cnt_q == CW'(TIMEOUT - 1);
    exp_done  = state_q == EXP_WAIT && bus.core_mod_exp_finish;
    to_exit   = expired && ((state_q == INV_WAIT && !bus.core_inverter_finish) ||
                            (state_q == EXP_WAIT && !bus.core_mod_exp_finish));
    cnt_d     = (state_q == INV_WAIT || state_q == EXP_WAIT) ? cnt_q + 1'b1 : '0;
    p_d       = accept ? bus.req_p : p_q;
    q_d       = accept ? bus.req_q : q_q;
    mode_d    = accept ? bus.req_mode : mode_q;
    msg_d     = accept ? bus.req_msg : msg_q;
    rsp_msg_d = exp_done ? bus.core_msg_out : to_exit ? '0 : rsp_msg_q;
    to_d      = exp_done ? 1'b0 : to_exit ? 1'b1 : to_q;
    jobs_d    = (state_q == RESP && bus.rsp_ready) ? jobs_q + 16'd1 : jobs_q;
  end
  // Moore outputs decoded from the current state
  always_comb begin
    bus.req_ready            = state_q == IDLE;
    bus.core_reset_inverter  = state_q == INV_RST;
    bus.core_reset_mod_exp   = state_q == EXP_RST;
    bus.rsp_valid            = state_q == RESP;
    bus.core_p               = p_q;
    bus.core_q               = q_q;
    bus.core_encrypt_decrypt = mode_q;
    bus.core_msg_in          = msg_q;
    bus.rsp_msg              = rsp_msg_q;
    bus.rsp_timeout          = to_q;
    busy                     = state_q != IDLE;
    job_count                = jobs_q;
  end
endmodule
